bit_permute_pipe: RTL and testbench

Clocked, runtime-programmable successor to the static bit reorderer: permutes a DATA_WIDTH-bit word through a mapping table loaded at run time rather than fixed by parameters. A shadow/active double-buffered map lets software reprogram the permutation without corrupting in-flight data. Sits on valid/ready data paths between capture/framing logic and downstream packers.

---
 rtl/bit_permute_pkg.sv | 27 ++
 rtl/bit_permute_map.sv | 53 +++++
 rtl/bit_permute_pipe.sv | 125 ++++++++++++
 tb/tb_bit_permute_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_permute_pkg.sv
// rtl/bit_permute_pkg.sv - shared types and helpers for the runtime bit permuter
// Contents: clog2 for index widths, commit FSM state enum, identity-map entry helper.
package bit_permute_pkg;

  typedef enum logic {
    ACTIVE      = 1'b0,
    COMMIT_WAIT = 1'b1
  } state_e;

  // Widest map index the identity helper can return; truncated to IDX_W at use.
  localparam int MAX_IDX_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int x = value - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Entry k of the identity map selects input bit k.
  function automatic logic [MAX_IDX_W-1:0] identity_sel(input int k);
    return MAX_IDX_W'(k);
  endfunction

endpackage

// File: rtl/bit_permute_map.sv
// rtl/bit_permute_map.sv - shadow/active double-buffered permutation map
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (both maps -> identity)
//   wr_en         : write shadow[wr_addr] = wr_sel (caller has range-checked)
//   wr_addr       : output bit position being written
//   wr_sel        : input bit that drives that output position
//   copy          : copy shadow to active at this edge
//   active_flat   : active map, entry k in bits [k*IDX_W +: IDX_W]
module bit_permute_map
  import bit_permute_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_addr,
  input  logic [IDX_W-1:0]            wr_sel,
  input  logic                        copy,
  output logic [DATA_WIDTH*IDX_W-1:0] active_flat
);

  logic [IDX_W-1:0] shadow_q [DATA_WIDTH];
  logic [IDX_W-1:0] shadow_d [DATA_WIDTH];
  logic [IDX_W-1:0] active_q [DATA_WIDTH];
  logic [IDX_W-1:0] active_d [DATA_WIDTH];

  // The copy reads shadow_q, so a write in the same cycle lands in shadow only.
  always_comb begin
    for (int k = 0; k < DATA_WIDTH; k++) begin
      active_d[k] = copy ? shadow_q[k] : active_q[k];
      shadow_d[k] = (wr_en && (wr_addr == IDX_W'(k))) ? wr_sel : shadow_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DATA_WIDTH; k++) begin
        shadow_q[k] <= IDX_W'(identity_sel(k));
        active_q[k] <= IDX_W'(identity_sel(k));
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_flat
    assign active_flat[g*IDX_W +: IDX_W] = active_q[g];
  end

endmodule

// File: rtl/bit_permute_pipe.sv
// rtl/bit_permute_pipe.sv - runtime-programmable registered bit permuter
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   perm_en             : 1 = permute through active map, 0 = pass through
//   in_valid/in_ready   : input handshake, in_data is the input word
//   out_valid/out_ready : output handshake, out_data is the registered result
//   cfg_we/addr/sel     : write shadow[cfg_addr] = cfg_sel
//   cfg_commit          : request shadow -> active copy
//   cfg_busy            : commit pending while the output drains
//   cfg_err             : one-cycle pulse after an out-of-range write
module bit_permute_pipe
  import bit_permute_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  bit COMMIT_DRAIN = 1'b1,
  localparam int IDX_W        = clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  perm_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [IDX_W-1:0]      cfg_sel,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  output logic                  cfg_err
);

  state_e                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [DATA_WIDTH*IDX_W-1:0] active_flat;
  logic [DATA_WIDTH-1:0]   perm_data;
  logic                    accept;
  logic                    copy;
  logic                    wr_ok;

  assign in_ready = (state_q == ACTIVE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // IDX_W can address more positions than DATA_WIDTH when it is not a power of two.
  assign wr_ok    = cfg_we && (int'(cfg_addr) < DATA_WIDTH) && (int'(cfg_sel) < DATA_WIDTH);

  bit_permute_map #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_map (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_ok),
    .wr_addr     (cfg_addr),
    .wr_sel      (cfg_sel),
    .copy        (copy),
    .active_flat (active_flat)
  );

  // Uses the map as it stands this cycle, so a word accepted on a swap edge sees the old map.
  always_comb begin
    perm_data = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      perm_data[k] = perm_en ? in_data[active_flat[k*IDX_W +: IDX_W]] : in_data[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    copy        = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cfg_err_d   = cfg_we && !wr_ok;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = perm_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ACTIVE: begin
        if (cfg_commit) begin
          if (!COMMIT_DRAIN || (!out_valid_q && !accept)) begin
            copy = 1'b1;
          end else begin
            state_d = COMMIT_WAIT;
          end
        end
      end
      COMMIT_WAIT: begin
        // Input is stalled here, so the output register only empties or holds.
        if (!out_valid_q || out_ready) begin
          copy    = 1'b1;
          state_d = ACTIVE;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACTIVE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_busy  = (state_q == COMMIT_WAIT);

endmodule

// File: tb/tb_bit_permute_pipe.sv
// tb/tb_bit_permute_pipe.sv - self-checking bench for bit_permute_pipe (32-bit drain and 24-bit immediate variants)
module tb_bit_permute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        perm_en, in_valid, out_ready, cfg_we, cfg_commit;
  logic [31:0] in_data;
  logic [4:0]  cfg_addr, cfg_sel;

  logic        a_in_ready, a_out_valid, a_busy, a_err;
  logic [31:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_busy, b_err;
  logic [23:0] b_out_data;

  always #5 clk = ~clk;

  bit_permute_pipe #(.DATA_WIDTH(32), .COMMIT_DRAIN(1'b1)) u_dut32 (
    .clk(clk), .rst(rst), .perm_en(perm_en),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_commit(cfg_commit), .cfg_busy(a_busy), .cfg_err(a_err)
  );

  bit_permute_pipe #(.DATA_WIDTH(24), .COMMIT_DRAIN(1'b0)) u_dut24 (
    .clk(clk), .rst(rst), .perm_en(perm_en),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data[23:0]),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_commit(cfg_commit), .cfg_busy(b_busy), .cfg_err(b_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = 32-bit drain variant, index 1 = 24-bit immediate variant.
  int          m_w  [2] = '{32, 24};
  int          m_dr [2] = '{1, 0};
  int          sh   [2][32];
  int          ac   [2][32];
  bit          m_wait [2];
  bit          m_ov   [2];
  bit          m_err  [2];
  logic [31:0] m_od   [2];

  function automatic bit m_rdy(input int i);
    return !m_wait[i] && (!m_ov[i] || out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 32; k++) begin
          sh[i][k] = k;
          ac[i][k] = k;
        end
        m_wait[i] = 1'b0;
        m_ov[i]   = 1'b0;
        m_err[i]  = 1'b0;
        m_od[i]   = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int          w;
        bit          acc, cp, ok;
        logic [31:0] p;
        w   = m_w[i];
        acc = in_valid && m_rdy(i);
        p   = 32'h0;
        for (int k = 0; k < w; k++) p[k] = perm_en ? in_data[ac[i][k]] : in_data[k];
        cp = 1'b0;
        if (!m_wait[i]) begin
          if (cfg_commit) begin
            if (m_dr[i] == 0 || (!m_ov[i] && !acc)) cp = 1'b1;
            else m_wait[i] = 1'b1;
          end
        end else if (!m_ov[i] || out_ready) begin
          cp        = 1'b1;
          m_wait[i] = 1'b0;
        end
        ok       = cfg_we && (int'(cfg_addr) < w) && (int'(cfg_sel) < w);
        m_err[i] = cfg_we && !ok;
        if (cp) for (int k = 0; k < 32; k++) ac[i][k] = sh[i][k];
        if (ok) sh[i][cfg_addr] = int'(cfg_sel);
        if (acc) begin
          m_ov[i] = 1'b1;
          m_od[i] = p;
        end else if (out_ready) begin
          m_ov[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_in_ready",  32'(a_in_ready),  32'(m_rdy(0)));
      chk("a_out_valid", 32'(a_out_valid), 32'(m_ov[0]));
      chk("a_out_data",  a_out_data,       m_od[0]);
      chk("a_cfg_busy",  32'(a_busy),      32'(m_wait[0]));
      chk("a_cfg_err",   32'(a_err),       32'(m_err[0]));
      chk("b_in_ready",  32'(b_in_ready),  32'(m_rdy(1)));
      chk("b_out_valid", 32'(b_out_valid), 32'(m_ov[1]));
      chk("b_out_data",  32'(b_out_data),  m_od[1]);
      chk("b_cfg_busy",  32'(b_busy),      32'(m_wait[1]));
      chk("b_cfg_err",   32'(b_err),       32'(m_err[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int s);
    cfg_we   = 1'b1;
    cfg_addr = 5'(a);
    cfg_sel  = 5'(s);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit pe);
    in_valid = 1'b1;
    in_data  = d;
    perm_en  = pe;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    perm_en    = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    out_ready  = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = 5'd0;
    cfg_sel    = 5'd0;
    cfg_commit = 1'b0;
    cyc();
    cyc();
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_out_data",  a_out_data,       32'h0);
    chk("rst_busy",      32'(a_busy),      32'h0);
    chk("rst_err",       32'(a_err),       32'h0);
    rst = 1'b0;
    chk("rst_in_ready",  32'(a_in_ready),  32'h1);

    // Identity map after reset, back-to-back words.
    send(32'h8000_0001, 1'b1);
    chk("ident_w0", a_out_data, 32'h8000_0001);
    chk("ident_rdy0", 32'(a_in_ready), 32'h1);
    send(32'h1234_5678, 1'b1);
    chk("ident_w1", a_out_data, 32'h1234_5678);
    chk("ident_rdy1", 32'(a_in_ready), 32'h1);
    cyc();

    // Bit reversal.
    for (int k = 0; k < 32; k++) wr(k, 31 - k);
    commit();
    send(32'h0000_0001, 1'b1);
    chk("rev_out", a_out_data, 32'h8000_0000);
    send(32'h1234_5678, 1'b0);
    chk("rev_bypass", a_out_data, 32'h1234_5678);

    // Drain-before-swap: shadow back to identity, commit while output is held.
    for (int k = 0; k < 32; k++) wr(k, k);
    out_ready = 1'b0;
    send(32'h0000_0001, 1'b1);
    chk("drain_held_old", a_out_data, 32'h8000_0000);
    commit();
    chk("drain_busy", 32'(a_busy), 32'h1);
    chk("drain_rdy", 32'(a_in_ready), 32'h0);
    cyc();
    chk("drain_busy2", 32'(a_busy), 32'h1);
    chk("drain_hold", a_out_data, 32'h8000_0000);
    out_ready = 1'b1;
    chk("drain_rdy2", 32'(a_in_ready), 32'h0);
    cyc();
    chk("drain_done", 32'(a_busy), 32'h0);
    chk("drain_rdy3", 32'(a_in_ready), 32'h1);
    send(32'h0000_0001, 1'b1);
    chk("drain_new_map", a_out_data, 32'h0000_0001);

    // Out-of-range writes on the 24-bit variant.
    wr(25, 0);
    chk("err_addr", 32'(b_err), 32'h1);
    chk("err_addr_32", 32'(a_err), 32'h0);
    cyc();
    chk("err_clear", 32'(b_err), 32'h0);
    wr(0, 30);
    chk("err_sel", 32'(b_err), 32'h1);
    cyc();
    commit();
    send(32'h0012_3456, 1'b1);
    chk("err_map_kept", 32'(b_out_data), 32'h0012_3456);
    cyc();

    // Write and commit in the same cycle: copy takes the pre-write shadow.
    cfg_we     = 1'b1;
    cfg_addr   = 5'd0;
    cfg_sel    = 5'd5;
    cfg_commit = 1'b1;
    cyc();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    send(32'h0000_0020, 1'b1);
    chk("wc_a_bit0_old", 32'(a_out_data[0]), 32'h0);
    chk("wc_b_bit0_old", 32'(b_out_data[0]), 32'h0);
    cyc();
    commit();
    send(32'h0000_0020, 1'b1);
    chk("wc_a_bit0_new", 32'(a_out_data[0]), 32'h1);
    chk("wc_b_bit0_new", 32'(b_out_data[0]), 32'h1);
    cyc();

    // Reset while a commit is pending.
    out_ready = 1'b0;
    send(32'h0000_FFFF, 1'b1);
    commit();
    chk("rstw_busy_pre", 32'(a_busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstw_busy", 32'(a_busy), 32'h0);
    chk("rstw_valid", 32'(a_out_valid), 32'h0);
    cyc();
    rst       = 1'b0;
    out_ready = 1'b1;
    send(32'hA5A5_0F0F, 1'b1);
    chk("rstw_ident_a", a_out_data, 32'hA5A5_0F0F);
    chk("rstw_ident_b", 32'(b_out_data), 32'h00A5_0F0F);
    cyc();

    // Randomised traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 4) != 0;
      perm_en    = 1'($urandom % 2);
      in_data    = $urandom;
      cfg_we     = ($urandom % 8) == 0;
      cfg_addr   = 5'($urandom);
      cfg_sel    = 5'($urandom);
      cfg_commit = ($urandom % 16) == 0;
      cyc();
    end
    in_valid   = 1'b0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    out_ready  = 1'b1;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
